// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes MIPS ALU instructions into ALU operands/func behind a 2-entry skid buffer
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [DATA_W-1:0] in_rs_val,
  input  logic [DATA_W-1:0] in_rt_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_func,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_illegal
);
  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [3:0]        func;
    logic [REG_AW-1:0] dest;
    logic              illegal;
  } entry_t;
  localparam entry_t RST = '{in1: '0, in2: '0, func: 4'b0100, dest: '0, illegal: 1'b0};
  localparam entry_t ILL = '{in1: '0, in2: '0, func: 4'b0100, dest: '0, illegal: 1'b1};
  logic [5:0] op, fn;
  logic [15:0] imm;
  logic [DATA_W-1:0] sext, zext;
  logic ill;
  logic unused_bits;
  entry_t dec, main_q, skid_q;
  logic main_v, skid_v, rdy, accept, drain;
  assign op = in_instr[31:26];
  assign fn = in_instr[5:0];
  assign imm = in_instr[15:0];
  assign sext = {{(DATA_W-16){imm[15]}}, imm};
  assign zext = {{(DATA_W-16){1'b0}}, imm};
  assign unused_bits = ^{in_instr[25:21], in_instr[10:6]};
  always_comb begin
    dec = '{in1: in_rs_val, in2: sext, func: 4'b0100, dest: in_instr[20:16], illegal: 1'b0};
    ill = 1'b0;
    case (op)
      6'h00: begin
        dec.in2 = in_rt_val;
        dec.dest = in_instr[15:11];
        case (fn)
          6'h20, 6'h21: dec.func = 4'b0100;
          6'h22, 6'h23: dec.func = 4'b1100;
          6'h24:        dec.func = 4'b0000;
          6'h25:        dec.func = 4'b0001;
          6'h26:        dec.func = 4'b0010;
          6'h2A:        dec.func = 4'b1101;
          6'h2B:        dec.func = 4'b0110;
          default:      ill = 1'b1;
        endcase
      end
      6'h08, 6'h09: dec.func = 4'b0100;
      6'h0A: dec.func = 4'b1101;
      6'h0B: dec.func = 4'b0110;
      6'h0C: begin dec.in2 = zext; dec.func = 4'b0000; end
      6'h0D: begin dec.in2 = zext; dec.func = 4'b0001; end
      6'h0E: begin dec.in2 = zext; dec.func = 4'b0010; end
      6'h0F: begin dec.in1 = '0; dec.in2 = {imm, {(DATA_W-16){1'b0}}}; end
      default: ill = 1'b1;
    endcase
    if (ill) dec = ILL;
  end
  assign accept = in_valid & rdy;
  assign drain = main_v & out_ready;
  // in_ready is registered: it reflects whether the skid slot will be empty next cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy <= 1'b0;
      main_q <= RST;
      skid_q <= RST;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy <= 1'b1;
    end else begin
      if (!main_v || drain) begin
        main_v <= skid_v | accept;
        if (skid_v || accept) main_q <= skid_v ? skid_q : dec;
        skid_v <= 1'b0;
      end else if (accept) begin
        skid_v <= 1'b1;
        skid_q <= dec;
      end
      rdy <= ~(main_v & ~drain & (skid_v | accept));
    end
  end
  assign in_ready = rdy;
  assign out_valid = main_v;
  assign alu_in1 = main_q.in1;
  assign alu_in2 = main_q.in2;
  assign alu_func = main_q.func;
  assign out_dest = main_q.dest;
  assign out_illegal = main_q.illegal;
endmodule
